// File: rtl/mem_store_unit.sv
// Store unit for the multi-cycle MIPS datapath: SW/SH/SB alignment check, lane build, memory handshake.
// Optional read-modify-write path for memories without byte enables: define STORE_RMW_EN.
module mem_store_unit #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_req_i,
    input  logic [2:0]    st_size_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [31:0]   st_data_i,
    output logic          st_busy_o,
    output logic          st_done_o,
    output logic          st_err_o,
    output logic          mem_valid_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          valid_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

    logic          req_err;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;

    always_comb begin
        req_err   = 1'b0;
        req_be    = 4'b0000;
        req_wdata = 32'h0;
        case (st_size_i)
            3'b000: begin
                req_be    = 4'b1111;
                req_wdata = st_data_i;
                req_err   = (st_addr_i[1:0] != 2'b00);
            end
            3'b001: begin
                req_be    = st_addr_i[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{st_data_i[15:0]}};
                req_err   = st_addr_i[0];
            end
            3'b010: begin
                req_be    = 4'b0001 << st_addr_i[1:0];
                req_wdata = {4{st_data_i[7:0]}};
            end
            default: req_err = 1'b1;
        endcase
    end

`ifdef STORE_RMW_EN
    logic        re_q;
    logic [3:0]  lane_be_q;
    logic [31:0] lane_mask;
    logic        req_partial;

    assign req_partial = (st_size_i != 3'b000);
    assign lane_mask   = {{8{lane_be_q[3]}}, {8{lane_be_q[2]}}, {8{lane_be_q[1]}}, {8{lane_be_q[0]}}};
    assign mem_re_o    = re_q;
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata_i;
    assign mem_re_o     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
`ifdef STORE_RMW_EN
            re_q      <= 1'b0;
            lane_be_q <= 4'b0000;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (st_req_i) begin
                        busy_q <= 1'b1;
                        if (req_err) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                            addr_q  <= {st_addr_i[AW-1:2], 2'b00};
                            wdata_q <= req_wdata;
`ifdef STORE_RMW_EN
                            lane_be_q <= req_be;
                            be_q      <= 4'b1111;
                            if (req_partial) begin
                                state_q <= StRead;
                                re_q    <= 1'b1;
                            end else begin
                                state_q <= StWrite;
                                we_q    <= 1'b1;
                            end
`else
                            be_q    <= req_be;
                            we_q    <= 1'b1;
                            state_q <= StWrite;
`endif
                        end
                    end
                end
`ifdef STORE_RMW_EN
                StRead: begin
                    if (mem_ready_i) begin
                        re_q    <= 1'b0;
                        we_q    <= 1'b1;
                        // Untouched lanes keep the word just read back.
                        wdata_q <= (mem_rdata_i & ~lane_mask) | (wdata_q & lane_mask);
                        state_q <= StWrite;
                    end
                end
`endif
                StWrite: begin
                    if (mem_ready_i) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        be_q    <= 4'b0000;
                        wdata_q <= 32'h0;
                    end
                end
                StDone, StErr: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign st_busy_o   = busy_q;
    assign st_done_o   = done_q;
    assign st_err_o    = err_q;
    assign mem_valid_o = valid_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit; STORE_RMW_EN selects the read-modify-write expectations.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_req;
    logic [2:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_busy, st_done, st_err;
    logic        mem_valid, mem_we, mem_re;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // {busy, done, err, valid, we, re}
    logic [5:0] ctl;
    assign ctl = {st_busy, st_done, st_err, mem_valid, mem_we, mem_re};

    always #5 clk = ~clk;

    mem_store_unit #(.AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_req_i   (st_req),
        .st_size_i  (st_size),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .st_busy_o  (st_busy),
        .st_done_o  (st_done),
        .st_err_o   (st_err),
        .mem_valid_o(mem_valid),
        .mem_we_o   (mem_we),
        .mem_re_o   (mem_re),
        .mem_addr_o (mem_addr),
        .mem_be_o   (mem_be),
        .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns in cycle 1.
    task automatic issue(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        st_req  = 1'b1;
        st_size = size;
        st_addr = addr;
        st_data = data;
        step();
        st_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== 74'h0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b addr=%h be=%b wdata=%h required all 0",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_sw();
        mem_ready = 1'b1;
        issue(3'b000, 32'h0000_1004, 32'h1234_5678);
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== {6'b100110, 32'h1004, 4'b1111, 32'h1234_5678}) begin
            errors++;
            $display("FAIL sw_write: ctl=%b addr=%h be=%b wdata=%h required 100110 1004 1111 12345678",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== {6'b110000, 32'h0, 4'b0, 32'h0}) begin
            errors++;
            $display("FAIL sw_done: ctl=%b addr=%h be=%b wdata=%h required 110000 and mem_* 0",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("FAIL sw_idle: ctl=%b required 000000", ctl);
        end
    endtask

`ifndef STORE_RMW_EN
    task automatic test_sb();
        mem_ready = 1'b1;
        issue(3'b010, 32'h0000_2003, 32'hAABB_CCDD);
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== {6'b100110, 32'h2000, 4'b1000, 32'hDDDD_DDDD}) begin
            errors++;
            $display("FAIL sb_write: ctl=%b addr=%h be=%b wdata=%h required 100110 2000 1000 dddddddd",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        checks++;
        if (st_done !== 1'b1) begin
            errors++;
            $display("FAIL sb_done: st_done=%b required 1", st_done);
        end
        step();
    endtask

    task automatic test_sh_stall();
        mem_ready = 1'b0;
        issue(3'b001, 32'h0000_3002, 32'h0000_BEEF);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            checks++;
            if ({ctl, mem_addr, mem_be, mem_wdata} !== {6'b100110, 32'h3000, 4'b1100, 32'hBEEF_BEEF}) begin
                errors++;
                $display("FAIL sh_stall_%0d: ctl=%b addr=%h be=%b wdata=%h required 100110 3000 1100 beefbeef",
                         i, ctl, mem_addr, mem_be, mem_wdata);
            end
            step();
        end
        checks++;
        if (ctl !== 6'b110000) begin
            errors++;
            $display("FAIL sh_done: ctl=%b required 110000", ctl);
        end
        step();
    endtask
`else
    task automatic test_rmw();
        mem_ready = 1'b1;
        mem_rdata = 32'h1122_3344;
        issue(3'b010, 32'h0000_0001, 32'h0000_00EE);
        checks++;
        if ({ctl, mem_addr, mem_be} !== {6'b100101, 32'h0, 4'b1111}) begin
            errors++;
            $display("FAIL rmw_read: ctl=%b addr=%h be=%b required 100101 0 1111", ctl, mem_addr, mem_be);
        end
        step();
        mem_rdata = 32'h0;
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== {6'b100110, 32'h0, 4'b1111, 32'h1122_EE44}) begin
            errors++;
            $display("FAIL rmw_write: ctl=%b addr=%h be=%b wdata=%h required 100110 0 1111 1122ee44",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        checks++;
        if (ctl !== 6'b110000) begin
            errors++;
            $display("FAIL rmw_done: ctl=%b required 110000", ctl);
        end
        step();
    endtask
`endif

    task automatic test_err(input logic [2:0] size, input logic [31:0] addr, input string name);
        mem_ready = 1'b1;
        issue(size, addr, 32'hFFFF_FFFF);
        checks++;
        if (ctl !== 6'b101000) begin
            errors++;
            $display("FAIL %s_err: ctl=%b required 101000", name, ctl);
        end
        step();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("FAIL %s_idle: ctl=%b required 000000", name, ctl);
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        issue(3'b000, 32'h0000_0040, 32'h5555_AAAA);
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_valid: mem_valid=%b required 1", mem_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ctl, mem_addr, mem_be, mem_wdata} !== 74'h0) begin
            errors++;
            $display("FAIL rstmid_clear: ctl=%b addr=%h be=%b wdata=%h required all 0",
                     ctl, mem_addr, mem_be, mem_wdata);
        end
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ctl !== 6'b000000) begin
                errors++;
                $display("FAIL rstmid_quiet_%0d: ctl=%b required 000000", i, ctl);
            end
        end
        issue(3'b000, 32'h0000_0044, 32'h0BAD_F00D);
        checks++;
        if ({ctl, mem_addr, mem_wdata} !== {6'b100110, 32'h44, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL rstmid_next: ctl=%b addr=%h wdata=%h required 100110 44 0badf00d",
                     ctl, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (st_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: st_done=%b required 1", st_done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        st_req  = 1'b1;
        st_size = 3'b000;
        st_addr = 32'h0000_0100;
        st_data = 32'h1111_1111;
        step();
        st_data = 32'hCAFE_F00D;
        checks++;
        if (mem_wdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL b2b_first: wdata=%h required 11111111", mem_wdata);
        end
        step();
        checks++;
        if (ctl !== 6'b110000) begin
            errors++;
            $display("FAIL b2b_done: ctl=%b required 110000", ctl);
        end
        step();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("FAIL b2b_idle: ctl=%b required 000000", ctl);
        end
        step();
        st_req = 1'b0;
        checks++;
        if ({ctl, mem_wdata} !== {6'b100110, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL b2b_second: ctl=%b wdata=%h required 100110 cafef00d", ctl, mem_wdata);
        end
        step();
        step();
    endtask

    initial begin
        st_req    = 1'b0;
        st_size   = 3'b000;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0;
        test_reset();
        test_sw();
`ifndef STORE_RMW_EN
        test_sb();
        test_sh_stall();
`else
        test_rmw();
`endif
        test_err(3'b001, 32'h0000_0001, "sh_odd");
        test_err(3'b000, 32'h0000_0002, "sw_half");
        test_err(3'b111, 32'h0000_0000, "bad_size");
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
